layer_sequencer: RTL and testbench

- Parametrised successor to the single-neuron control unit.
- Sequences one complete fully-connected layer: for each of N_NEURONS neurons it clears the MAC ALU, streams N_INPUTS operand reads through the address generator, and waits out the ALU pipeline. It then strobes the neuron result into the output buffer.
- Sits between the top-level host handshake (start/done) and the AG, ALU and output-buffer datapath.

---
 rtl/layer_sequencer.sv | 156 +++++++++++++++
 tb/tb_layer_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks N_NEURONS neurons through CLEAR/ACCUM/DRAIN/WRITE and pulses done.
// Optional bias read per neuron when LAYER_SEQ_BIAS_EN is defined (adds the bias_sel output).
module layer_sequencer #(
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 3,
    parameter int PIPE_LAT  = 2,
    parameter int IN_AW     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    parameter int N_AW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
`ifdef LAYER_SEQ_BIAS_EN
    parameter int W_AW      = ((N_INPUTS + 1) * N_NEURONS > 1) ? $clog2((N_INPUTS + 1) * N_NEURONS) : 1
`else
    parameter int W_AW      = (N_INPUTS * N_NEURONS > 1) ? $clog2(N_INPUTS * N_NEURONS) : 1
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            forget,
    output logic            busy,
    output logic            done,
    output logic            alu_clr,
    output logic            ag_read,
`ifdef LAYER_SEQ_BIAS_EN
    output logic            bias_sel,
`endif
    output logic [IN_AW-1:0] in_addr,
    output logic [W_AW-1:0]  w_addr,
    output logic             out_we,
    output logic [N_AW-1:0]  out_idx
);

`ifdef LAYER_SEQ_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif
    localparam int STRIDE = N_INPUTS + BIAS;
    localparam int LAST   = STRIDE - 1;
    localparam int IDX_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int DC_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [W_AW-1:0]   base;
    logic [N_AW-1:0]   neuron;
    logic [DC_W-1:0]   drain_cnt;

    // NOTE: every output is a register loaded with the value for the state being entered,
    // so each transition below also sets what the next cycle shows; all state uses <=.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            base      <= '0;
            neuron    <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            alu_clr   <= 1'b0;
            ag_read   <= 1'b0;
            in_addr   <= '0;
            w_addr    <= '0;
            out_we    <= 1'b0;
            out_idx   <= '0;
`ifdef LAYER_SEQ_BIAS_EN
            bias_sel  <= 1'b0;
`endif
        end else begin
            // NOTE: strobes and addresses default low each cycle; only the entered state raises them.
            alu_clr  <= 1'b0;
            ag_read  <= 1'b0;
            done     <= 1'b0;
            out_we   <= 1'b0;
            in_addr  <= '0;
            w_addr   <= '0;
            out_idx  <= '0;
`ifdef LAYER_SEQ_BIAS_EN
            bias_sel <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_CLEAR;
                        neuron  <= '0;
                        base    <= '0;
                        busy    <= 1'b1;
                        alu_clr <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state   <= S_ACCUM;
                    idx     <= '0;
                    ag_read <= 1'b1;
                    w_addr  <= base;
                end
                S_ACCUM: begin
                    if (forget) begin
                        state   <= S_CLEAR;
                        alu_clr <= 1'b1;
                    end else if (idx == IDX_W'(LAST)) begin
                        if (PIPE_LAT > 0) begin
                            state     <= S_DRAIN;
                            drain_cnt <= DC_W'(PIPE_LAT - 1);
                        end else begin
                            state   <= S_WRITE;
                            out_we  <= 1'b1;
                            out_idx <= neuron;
                        end
                    end else begin
                        idx     <= idx + IDX_W'(1);
                        ag_read <= 1'b1;
                        w_addr  <= base + W_AW'(idx) + W_AW'(1);
`ifdef LAYER_SEQ_BIAS_EN
                        // The bias read addresses input 0 but the datapath substitutes constant 1.
                        if (idx == IDX_W'(N_INPUTS - 1)) bias_sel <= 1'b1;
                        else in_addr <= IN_AW'(idx + IDX_W'(1));
`else
                        in_addr <= IN_AW'(idx + IDX_W'(1));
`endif
                    end
                end
                S_DRAIN: begin
                    if (forget) begin
                        state   <= S_CLEAR;
                        alu_clr <= 1'b1;
                    end else if (drain_cnt == '0) begin
                        state   <= S_WRITE;
                        out_we  <= 1'b1;
                        out_idx <= neuron;
                    end else begin
                        drain_cnt <= drain_cnt - DC_W'(1);
                    end
                end
                S_WRITE: begin
                    if (neuron == N_AW'(N_NEURONS - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= S_CLEAR;
                        neuron  <= neuron + N_AW'(1);
                        base    <= base + W_AW'(STRIDE);
                        alu_clr <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: default and minimal (1/1/0) instances against a timeline model
// built from the per-neuron cycle budget and forget rules.
module tb_layer_sequencer;

    localparam int NI = 4, NN = 3, PL = 2;
`ifdef LAYER_SEQ_BIAS_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif
    localparam int S = NI + B;
    localparam int D0_IN_AW = (NI > 1) ? $clog2(NI) : 1;
    localparam int D0_N_AW  = (NN > 1) ? $clog2(NN) : 1;
    localparam int D0_W_AW  = (S * NN > 1) ? $clog2(S * NN) : 1;
    localparam int MAXC = 511;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic s0_start = 1'b0, s0_forget = 1'b0;
    logic d0_busy, d0_done, d0_alu_clr, d0_ag_read, d0_out_we;
    logic [D0_IN_AW-1:0] d0_in_addr;
    logic [D0_W_AW-1:0]  d0_w_addr;
    logic [D0_N_AW-1:0]  d0_out_idx;

    logic s1_start = 1'b0, s1_forget = 1'b0;
    logic d1_busy, d1_done, d1_alu_clr, d1_ag_read, d1_out_we;
    logic [0:0] d1_in_addr, d1_w_addr, d1_out_idx;
`ifdef LAYER_SEQ_BIAS_EN
    logic d0_bias_sel, d1_bias_sel;
`endif

    layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .PIPE_LAT(PL)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(s0_start), .forget(s0_forget),
        .busy(d0_busy), .done(d0_done), .alu_clr(d0_alu_clr), .ag_read(d0_ag_read),
`ifdef LAYER_SEQ_BIAS_EN
        .bias_sel(d0_bias_sel),
`endif
        .in_addr(d0_in_addr), .w_addr(d0_w_addr), .out_we(d0_out_we), .out_idx(d0_out_idx)
    );

    layer_sequencer #(.N_INPUTS(1), .N_NEURONS(1), .PIPE_LAT(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(s1_start), .forget(s1_forget),
        .busy(d1_busy), .done(d1_done), .alu_clr(d1_alu_clr), .ag_read(d1_ag_read),
`ifdef LAYER_SEQ_BIAS_EN
        .bias_sel(d1_bias_sel),
`endif
        .in_addr(d1_in_addr), .w_addr(d1_w_addr), .out_we(d1_out_we), .out_idx(d1_out_idx)
    );

    typedef struct packed {
        logic        busy, done, alu_clr, ag_read, bias_sel, out_we;
        logic [15:0] in_addr, w_addr, out_idx;
    } obs_t;

    obs_t exp_arr [0:MAXC];
    obs_t obs_arr [0:MAXC];
    bit   fplan   [0:MAXC];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic obs_t get_obs(input int which);
        obs_t o;
        o = '0;
        if (which == 0) begin
            o.busy = d0_busy; o.done = d0_done; o.alu_clr = d0_alu_clr; o.ag_read = d0_ag_read;
            o.out_we = d0_out_we; o.in_addr = 16'(d0_in_addr); o.w_addr = 16'(d0_w_addr);
            o.out_idx = 16'(d0_out_idx);
`ifdef LAYER_SEQ_BIAS_EN
            o.bias_sel = d0_bias_sel;
`endif
        end else begin
            o.busy = d1_busy; o.done = d1_done; o.alu_clr = d1_alu_clr; o.ag_read = d1_ag_read;
            o.out_we = d1_out_we; o.in_addr = 16'(d1_in_addr); o.w_addr = 16'(d1_w_addr);
            o.out_idx = 16'(d1_out_idx);
`ifdef LAYER_SEQ_BIAS_EN
            o.bias_sel = d1_bias_sel;
`endif
        end
        return o;
    endfunction

    // Addresses matter only while reading, the index only while writing.
    function automatic obs_t mask_obs(input obs_t o, input obs_t e);
        obs_t m;
        m = o;
        if (!e.ag_read) begin m.in_addr = e.in_addr; m.w_addr = e.w_addr; end
        if (!e.out_we) m.out_idx = e.out_idx;
        return m;
    endfunction

    // Timeline model: each pass is 1 clear, s reads, pl drain cycles, then 1 write;
    // a forget seen in a read/drain cycle restarts the same neuron on the next cycle.
    task automatic build_model(input int ni, input int nn, input int pl, output int len);
        int r, s, base;
        bit aborted;
        s = ni + B; r = 1; base = 0;
        for (int i = 0; i <= MAXC; i++) exp_arr[i] = '0;
        for (int n = 0; n < nn; n++) begin
            aborted = 1'b1;
            while (aborted) begin
                aborted = 1'b0;
                exp_arr[r].alu_clr = 1'b1;
                for (int t = 1; t <= s + pl; t++) begin
                    if (t <= s) begin
                        exp_arr[r+t].ag_read  = 1'b1;
                        exp_arr[r+t].in_addr  = 16'((t <= ni) ? t - 1 : 0);
                        exp_arr[r+t].w_addr   = 16'(base + t - 1);
                        exp_arr[r+t].bias_sel = (t > ni);
                    end
                    if (fplan[r+t]) begin aborted = 1'b1; r = r + t + 1; break; end
                end
            end
            exp_arr[r+s+pl+1].out_we  = 1'b1;
            exp_arr[r+s+pl+1].out_idx = 16'(n);
            r = r + s + pl + 2;
            base = base + s;
        end
        exp_arr[r].done = 1'b1;
        for (int i = 1; i < r; i++) exp_arr[i].busy = 1'b1;
        len = r;
    endtask

    task automatic drive(input int which, input logic st, input logic fg);
        s0_start  = (which == 0) ? st : 1'b0;
        s0_forget = (which == 0) ? fg : 1'b0;
        s1_start  = (which == 1) ? st : 1'b0;
        s1_forget = (which == 1) ? fg : 1'b0;
    endtask

    // Launch a layer (start sampled at edge k) and record outputs of cycles k+1..k+n.
    // smode: 0 start low, 1 random start, 2 start high, applied for cycles up to suntil.
    task automatic capture(input int which, input int n, input int smode, input int suntil);
        logic st;
        @(posedge clk); #1;
        drive(which, 1'b1, 1'b0);
        @(posedge clk); #1;
        for (int r = 1; r <= n; r++) begin
            if (r > suntil || smode == 0) st = 1'b0;
            else if (smode == 2) st = 1'b1;
            else st = 1'($urandom_range(0, 1));
            drive(which, st, fplan[r]);
            @(negedge clk);
            obs_arr[r] = get_obs(which);
            if (r < n) begin @(posedge clk); #1; end
        end
        drive(which, 1'b0, 1'b0);
    endtask

    function automatic int first_done(input int n);
        for (int r = 1; r <= n; r++) if (obs_arr[r].done) return r;
        return 0;
    endfunction

    task automatic test_reset();
        obs_t o;
        #2 reset_n = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            o = get_obs(w);
            n_tests++;
            if (o !== '0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d got=%h exp=0", w, o);
            end
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_layer();
        int len, fd;
        obs_t m;
        for (int i = 0; i <= MAXC; i++) fplan[i] = 1'b0;
        build_model(NI, NN, PL, len);
        capture(0, len + 2, 0, 0);
        for (int r = 1; r <= len + 2; r++) begin
            m = mask_obs(obs_arr[r], exp_arr[r]);
            n_tests++;
            if (m !== exp_arr[r]) begin
                n_fail++;
                $display("FAIL layer cycle=%0d got=%h exp=%h", r, m, exp_arr[r]);
            end
        end
        fd = first_done(len + 2);
        n_tests++;
        if (fd !== NN * (2 + S + PL) + 1) begin
            n_fail++;
            $display("FAIL layer_done_cycle got=%0d exp=%0d", fd, NN * (2 + S + PL) + 1);
        end
    endtask

    task automatic test_forget();
        int len, fd, nwe, rf;
        obs_t m;
        for (int i = 0; i <= MAXC; i++) fplan[i] = 1'b0;
        // Forget seen at the edge ending neuron 1's second read.
        rf = 1 + (2 + S + PL) + 2;
        fplan[rf] = 1'b1;
        build_model(NI, NN, PL, len);
        capture(0, len + 2, 0, 0);
        for (int r = 1; r <= len + 2; r++) begin
            m = mask_obs(obs_arr[r], exp_arr[r]);
            n_tests++;
            if (m !== exp_arr[r]) begin
                n_fail++;
                $display("FAIL forget cycle=%0d got=%h exp=%h", r, m, exp_arr[r]);
            end
        end
        fd = first_done(len + 2);
        n_tests++;
        if (fd !== NN * (2 + S + PL) + 1 + 3) begin
            n_fail++;
            $display("FAIL forget_done_cycle got=%0d exp=%0d", fd, NN * (2 + S + PL) + 4);
        end
        nwe = 0;
        for (int r = 1; r <= len + 2; r++)
            if (obs_arr[r].out_we === 1'b1 && obs_arr[r].out_idx === 16'd1) nwe++;
        n_tests++;
        if (nwe !== 1) begin
            n_fail++;
            $display("FAIL forget_writes_idx1 got=%0d exp=1", nwe);
        end
    endtask

    task automatic test_random(input int which, input int iters);
        int len, ni, nn, pl;
        obs_t m;
        ni = (which == 0) ? NI : 1;
        nn = (which == 0) ? NN : 1;
        pl = (which == 0) ? PL : 0;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i <= MAXC; i++) fplan[i] = (i <= 300) && ($urandom_range(0, 5) == 0);
            build_model(ni, nn, pl, len);
            capture(which, len + 2, (it % 3 == 0) ? 2 : 1, len);
            for (int r = 1; r <= len + 2; r++) begin
                m = mask_obs(obs_arr[r], exp_arr[r]);
                n_tests++;
                if (m !== exp_arr[r]) begin
                    n_fail++;
                    $display("FAIL random dut%0d iter=%0d cycle=%0d got=%h exp=%h",
                             which, it, r, m, exp_arr[r]);
                end
            end
        end
    endtask

    task automatic test_small();
        int len, fd;
        obs_t m;
        for (int i = 0; i <= MAXC; i++) fplan[i] = 1'b0;
        build_model(1, 1, 0, len);
        capture(1, len + 2, 0, 0);
        for (int r = 1; r <= len + 2; r++) begin
            m = mask_obs(obs_arr[r], exp_arr[r]);
            n_tests++;
            if (m !== exp_arr[r]) begin
                n_fail++;
                $display("FAIL small cycle=%0d got=%h exp=%h", r, m, exp_arr[r]);
            end
        end
        fd = first_done(len + 2);
        n_tests++;
        if (fd !== 4 + B) begin
            n_fail++;
            $display("FAIL small_done_cycle got=%0d exp=%0d", fd, 4 + B);
        end
    endtask

    task automatic test_back_to_back();
        int len;
        bit seen;
        obs_t m;
        for (int i = 0; i <= MAXC; i++) fplan[i] = 1'b0;
        build_model(NI, NN, PL, len);
        // Start stays high through DONE and the following IDLE cycle: relaunch follows.
        exp_arr[len+2].alu_clr = 1'b1;
        exp_arr[len+2].busy    = 1'b1;
        capture(0, len + 2, 2, len + 1);
        for (int r = 1; r <= len + 2; r++) begin
            m = mask_obs(obs_arr[r], exp_arr[r]);
            n_tests++;
            if (m !== exp_arr[r]) begin
                n_fail++;
                $display("FAIL back_to_back cycle=%0d got=%h exp=%h", r, m, exp_arr[r]);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (d0_done === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL back_to_back_second_done got=0 exp=1 within 200 cycles");
        end
    endtask

    task automatic test_async_reset();
        int len;
        obs_t m, o;
        for (int i = 0; i <= MAXC; i++) fplan[i] = 1'b0;
        build_model(NI, NN, PL, len);
        capture(0, S + 2, 0, 0);
        for (int r = 1; r <= S + 2; r++) begin
            m = mask_obs(obs_arr[r], exp_arr[r]);
            n_tests++;
            if (m !== exp_arr[r]) begin
                n_fail++;
                $display("FAIL pre_reset cycle=%0d got=%h exp=%h", r, m, exp_arr[r]);
            end
        end
        #1 reset_n = 1'b0;
        #1 o = get_obs(0);
        n_tests++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=0", o);
        end
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 1'($urandom_range(0, 1)));
            @(negedge clk);
            o = get_obs(0);
            n_tests++;
            if (o !== '0) begin
                n_fail++;
                $display("FAIL post_reset_idle cycle=%0d got=%h exp=0", c, o);
            end
        end
        drive(0, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_layer();
        test_forget();
        test_small();
        test_back_to_back();
        test_async_reset();
        test_layer();
        test_random(0, 20);
        test_random(1, 10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
